// File: rtl/reg_file_sb.sv
// Clocked register file with NREAD combinational read ports, one write port and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward the write port onto matching read ports in the same cycle.
module reg_file_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_en,
    input  logic [AW-1:0]         issue_addr,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:1] busy;

    // NOTE: the array is plain flops rather than a RAM macro, so it can take the synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en && wr_addr != '0) begin
                regs[wr_addr] <= wr_data;
            end
            if (flush) begin
                busy <= '0;
            end else begin
                for (int i = 1; i < NREGS; i++) begin
                    // A same-cycle issue marks the new producer, so it beats the writeback clear.
                    if (issue_en && issue_addr == AW'(i)) begin
                        busy[i] <= 1'b1;
                    end else if (wr_en && wr_addr == AW'(i)) begin
                        busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy_vec = {busy, 1'b0};

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = rs_addr[k*AW +: AW];
`ifdef RF_BYPASS_EN
        logic hit;
        assign hit = wr_en && (wr_addr != '0) && (addr == wr_addr);
        assign rs_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? wr_data : regs[addr]);
        assign rs_busy[k]              = hit ? 1'b0 : busy_vec[addr];
`else
        assign rs_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : regs[addr];
        assign rs_busy[k]              = busy_vec[addr];
`endif
    end

endmodule
